// File: rtl/mbinit_sb_handshake_if.sv
// Sideband handshake bundle between an MBINIT substate engine and the sideband TX/RX logic.
// The engine itself uses the slave view; the stimulus/sideband side uses the master view.
interface mbinit_sb_handshake_if #(
   parameter int MSG_W = 4
);
   logic             i_start;
   logic [MSG_W-1:0] i_RX_SbMessage;
   logic             i_msg_valid;
   logic             i_falling_edge_busy;
   logic [MSG_W-1:0] o_TX_SbMessage;
   logic             o_tx_valid;
   logic             o_end;
   logic             o_timeout;

   modport master (
      output i_start, i_RX_SbMessage, i_msg_valid, i_falling_edge_busy,
      input  o_TX_SbMessage, o_tx_valid, o_end, o_timeout
   );

   modport slave (
      input  i_start, i_RX_SbMessage, i_msg_valid, i_falling_edge_busy,
      output o_TX_SbMessage, o_tx_valid, o_end, o_timeout
   );
endinterface

// File: rtl/mbinit_sb_handshake.sv
// MBINIT sideband handshake: concurrent initiator (REQ->RSP) and responder (REQ->RSP) exchanges
// sharing one TX port, responder first. Optional watchdog enabled by MBINIT_SB_WATCHDOG_EN.
module mbinit_sb_handshake #(
   parameter int               MSG_W       = 4,
   parameter logic [MSG_W-1:0] REQ_CODE    = MSG_W'(1),
   parameter logic [MSG_W-1:0] RSP_CODE    = MSG_W'(2),
   parameter int               TIMEOUT_CYC = 4096
) (
   input logic                  CLK,
   input logic                  rst,
   mbinit_sb_handshake_if.slave sb
);

   if (TIMEOUT_CYC < 2) begin : g_timeout_range_chk
      $error("TIMEOUT_CYC must be at least 2");
   end

   typedef enum logic [2:0] {I_IDLE, I_SEND, I_WAIT_BUSY, I_WAIT_RSP, I_DONE} init_state_t;
   typedef enum logic [2:0] {R_IDLE, R_WAIT_REQ, R_SEND, R_WAIT_BUSY, R_DONE} resp_state_t;
   typedef enum logic [1:0] {OWN_NONE, OWN_INIT, OWN_RESP} owner_t;

   init_state_t      init_state, init_state_nxt;
   resp_state_t      resp_state, resp_state_nxt;
   owner_t           owner, owner_nxt;
   logic             rsp_pend, rsp_pend_nxt;
   logic             tx_valid_q, tx_valid_nxt;
   logic [MSG_W-1:0] tx_msg_q, tx_msg_nxt;
   logic             end_q, end_nxt;
   logic             timeout_q;
   logic             wd_fire;
   logic             park;
   logic             req_hit, rsp_hit, busy_drop;
   logic             grant_resp, grant_init;

   assign req_hit   = sb.i_msg_valid && (sb.i_RX_SbMessage == REQ_CODE);
   assign rsp_hit   = sb.i_msg_valid && (sb.i_RX_SbMessage == RSP_CODE);
   assign busy_drop = sb.i_falling_edge_busy && (owner != OWN_NONE);

   // Responder owns the port whenever it is ready and the port is free.
   assign grant_resp = (resp_state == R_SEND) && (owner == OWN_NONE);
   assign grant_init = (init_state == I_SEND) && (owner == OWN_NONE) && !grant_resp;

   assign park = !sb.i_start || timeout_q || wd_fire;

`ifdef MBINIT_SB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
   logic [WD_W-1:0] wd_cnt;

   assign wd_fire = sb.i_start && !timeout_q && !end_q && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge CLK) begin
      if (rst || !sb.i_start) begin
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (!end_q && (wd_cnt != WD_W'(TIMEOUT_CYC))) wd_cnt <= wd_cnt + 1'b1;
         if (wd_fire) timeout_q <= 1'b1;
      end
   end
`else
   assign wd_fire   = 1'b0;
   assign timeout_q = 1'b0;
`endif

   always_comb begin
      init_state_nxt = init_state;
      resp_state_nxt = resp_state;
      owner_nxt      = owner;
      rsp_pend_nxt   = rsp_pend;
      tx_valid_nxt   = 1'b0;
      tx_msg_nxt     = '0;
      end_nxt        = (init_state == I_DONE) && (resp_state == R_DONE);

      if (park) begin
         init_state_nxt = I_IDLE;
         resp_state_nxt = R_IDLE;
         owner_nxt      = OWN_NONE;
         rsp_pend_nxt   = 1'b0;
         end_nxt        = 1'b0;
      end else begin
         unique case (init_state)
            I_IDLE:      init_state_nxt = I_SEND;
            I_SEND: begin
               if (rsp_hit) rsp_pend_nxt = 1'b1;
               if (grant_init) init_state_nxt = I_WAIT_BUSY;
            end
            I_WAIT_BUSY: begin
               if (rsp_hit) rsp_pend_nxt = 1'b1;
               if (busy_drop && (owner == OWN_INIT)) init_state_nxt = I_WAIT_RSP;
            end
            I_WAIT_RSP: begin
               if (rsp_hit || rsp_pend) begin
                  init_state_nxt = I_DONE;
                  rsp_pend_nxt   = 1'b0;
               end
            end
            I_DONE:      init_state_nxt = I_DONE;
            default:     init_state_nxt = I_IDLE;
         endcase

         // A REQ seen together with start is consumed immediately rather than lost.
         unique case (resp_state)
            R_IDLE:      resp_state_nxt = req_hit ? R_SEND : R_WAIT_REQ;
            R_WAIT_REQ:  if (req_hit) resp_state_nxt = R_SEND;
            R_SEND:      if (grant_resp) resp_state_nxt = R_WAIT_BUSY;
            R_WAIT_BUSY: if (busy_drop && (owner == OWN_RESP)) resp_state_nxt = R_DONE;
            R_DONE:      resp_state_nxt = R_DONE;
            default:     resp_state_nxt = R_IDLE;
         endcase

         if (grant_resp) begin
            tx_valid_nxt = 1'b1;
            tx_msg_nxt   = RSP_CODE;
            owner_nxt    = OWN_RESP;
         end else if (grant_init) begin
            tx_valid_nxt = 1'b1;
            tx_msg_nxt   = REQ_CODE;
            owner_nxt    = OWN_INIT;
         end else if (busy_drop) begin
            owner_nxt    = OWN_NONE;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (rst) begin
         init_state <= I_IDLE;
         resp_state <= R_IDLE;
         owner      <= OWN_NONE;
         rsp_pend   <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_msg_q   <= '0;
         end_q      <= 1'b0;
      end else begin
         init_state <= init_state_nxt;
         resp_state <= resp_state_nxt;
         owner      <= owner_nxt;
         rsp_pend   <= rsp_pend_nxt;
         tx_valid_q <= tx_valid_nxt;
         tx_msg_q   <= tx_msg_nxt;
         end_q      <= end_nxt;
      end
   end

   assign sb.o_tx_valid     = tx_valid_q;
   assign sb.o_TX_SbMessage = tx_msg_q;
   assign sb.o_end          = end_q;
   assign sb.o_timeout      = timeout_q;

endmodule

// File: tb/tb_mbinit_sb_handshake.sv
// Directed bench for mbinit_sb_handshake: per-edge vector table plus hand-written
// reset and watchdog sequences.
module tb_mbinit_sb_handshake;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mbinit_sb_handshake_if #(.MSG_W(4)) sb ();

   mbinit_sb_handshake #(
      .MSG_W(4), .REQ_CODE(4'd1), .RSP_CODE(4'd2), .TIMEOUT_CYC(16)
   ) dut (
      .CLK(clk),
      .rst(rst),
      .sb (sb)
   );

   // Inputs are sampled at one edge; expected outputs are those visible after it.
   typedef struct {
      logic       rst;
      logic       start;
      logic       vld;
      logic [3:0] msg;
      logic       busy;
      logic       exp_vld;
      logic [3:0] exp_msg;
      logic       exp_end;
      string      tag;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic v(input logic r, input logic s, input logic vl, input logic [3:0] m,
                    input logic b, input logic ev, input logic [3:0] em, input logic ee,
                    input string tag);
      vec_t x;
      x.rst = r; x.start = s; x.vld = vl; x.msg = m; x.busy = b;
      x.exp_vld = ev; x.exp_msg = em; x.exp_end = ee; x.tag = tag;
      vecs.push_back(x);
   endtask

   task automatic drive(input logic r, input logic s, input logic vl, input logic [3:0] m,
                        input logic b);
      rst                    = r;
      sb.i_start             = s;
      sb.i_msg_valid         = vl;
      sb.i_RX_SbMessage      = m;
      sb.i_falling_edge_busy = b;
   endtask

   initial begin
      int first_to;
      int tx_after;
      int tx_cnt;
      int to_cnt;

      drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

      //     rst start vld msg busy | tx  msg end  tag
      // Normal order
      v(0,1,0,4'd0,0, 0,4'd0,0, "norm_start");
      v(0,1,0,4'd0,0, 1,4'd1,0, "norm_req_tx");
      v(0,1,0,4'd0,0, 0,4'd0,0, "norm_gap1");
      v(0,1,0,4'd0,0, 0,4'd0,0, "norm_gap2");
      v(0,1,0,4'd0,1, 0,4'd0,0, "norm_busy");
      v(0,1,1,4'd1,0, 0,4'd0,0, "norm_rx_req");
      v(0,1,0,4'd0,0, 1,4'd2,0, "norm_rsp_tx");
      v(0,1,1,4'd2,0, 0,4'd0,0, "norm_rx_rsp");
      v(0,1,0,4'd0,0, 0,4'd0,0, "norm_wait");
      v(0,1,0,4'd0,1, 0,4'd0,0, "norm_resp_busy");
      v(0,1,0,4'd0,0, 0,4'd0,1, "norm_end");
      v(0,1,0,4'd0,0, 0,4'd0,1, "norm_end_hold");
      v(0,0,0,4'd0,0, 0,4'd0,0, "norm_stop");
      // Contention: REQ arrives with start, responder goes first
      v(0,1,1,4'd1,0, 0,4'd0,0, "cont_start_req");
      v(0,1,0,4'd0,0, 1,4'd2,0, "cont_rsp_first");
      v(0,1,0,4'd0,0, 0,4'd0,0, "cont_blocked");
      v(0,1,0,4'd0,1, 0,4'd0,0, "cont_busy");
      v(0,1,0,4'd0,0, 1,4'd1,0, "cont_req_after");
      v(0,1,0,4'd0,1, 0,4'd0,0, "cont_init_busy");
      v(0,1,1,4'd2,0, 0,4'd0,0, "cont_rx_rsp");
      v(0,1,0,4'd0,0, 0,4'd0,1, "cont_end");
      v(0,0,0,4'd0,0, 0,4'd0,0, "cont_stop");
      // Early RSP before the initiator's busy-drop
      v(0,1,0,4'd0,0, 0,4'd0,0, "early_start");
      v(0,1,0,4'd0,0, 1,4'd1,0, "early_req_tx");
      v(0,1,1,4'd2,0, 0,4'd0,0, "early_rsp");
      v(0,1,1,4'd1,0, 0,4'd0,0, "early_rx_req");
      v(0,1,0,4'd0,1, 0,4'd0,0, "early_busy");
      v(0,1,0,4'd0,0, 1,4'd2,0, "early_rsp_tx");
      v(0,1,0,4'd0,0, 0,4'd0,0, "early_wait");
      v(0,1,0,4'd0,1, 0,4'd0,0, "early_resp_busy");
      v(0,1,0,4'd0,0, 0,4'd0,1, "early_end");
      v(0,0,0,4'd0,0, 0,4'd0,0, "early_stop");
      // Noise: unknown codes, unqualified data, stray busy-drops
      v(0,0,1,4'd7,1, 0,4'd0,0, "noise_idle");
      v(0,0,1,4'd1,0, 0,4'd0,0, "noise_req_nostart");
      v(0,1,1,4'd7,0, 0,4'd0,0, "noise_start");
      v(0,1,0,4'd0,0, 1,4'd1,0, "noise_req_tx");
      v(0,1,0,4'd0,1, 0,4'd0,0, "noise_busy");
      v(0,1,1,4'd7,1, 0,4'd0,0, "noise_stray");
      v(0,1,0,4'd2,0, 0,4'd0,0, "noise_novld");
      v(0,1,1,4'd1,0, 0,4'd0,0, "noise_rx_req");
      v(0,1,0,4'd0,1, 1,4'd2,0, "noise_rsp_tx");
      v(0,1,1,4'd2,0, 0,4'd0,0, "noise_rx_rsp");
      v(0,1,0,4'd0,1, 0,4'd0,0, "noise_resp_busy");
      v(0,1,0,4'd0,0, 0,4'd0,1, "noise_end");
      v(0,0,0,4'd0,0, 0,4'd0,0, "noise_stop");
      // Abort while waiting for RSP, then clean restart
      v(0,1,0,4'd0,0, 0,4'd0,0, "abort_start");
      v(0,1,0,4'd0,0, 1,4'd1,0, "abort_req_tx");
      v(0,1,0,4'd0,1, 0,4'd0,0, "abort_busy");
      v(0,0,0,4'd0,0, 0,4'd0,0, "abort_drop");
      v(0,1,0,4'd0,0, 0,4'd0,0, "abort_restart");
      v(0,1,0,4'd0,0, 1,4'd1,0, "abort_req_again");
      v(0,1,0,4'd0,1, 0,4'd0,0, "abort_busy2");
      v(0,1,1,4'd1,0, 0,4'd0,0, "abort_rx_req");
      v(0,1,0,4'd0,0, 1,4'd2,0, "abort_rsp_tx");
      v(0,1,1,4'd2,1, 0,4'd0,0, "abort_both_done");
      v(0,1,0,4'd0,0, 0,4'd0,1, "abort_end");
      v(0,0,0,4'd0,0, 0,4'd0,0, "abort_stop");
      // Reset mid-exchange
      v(0,1,0,4'd0,0, 0,4'd0,0, "rst_start");
      v(0,1,0,4'd0,0, 1,4'd1,0, "rst_req_tx");
      v(1,1,0,4'd0,0, 0,4'd0,0, "rst_mid");
      v(0,1,0,4'd0,0, 0,4'd0,0, "rst_release");
      v(0,1,0,4'd0,0, 1,4'd1,0, "rst_req_again");
      v(0,0,0,4'd0,0, 0,4'd0,0, "rst_stop");

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("reset_tx_valid", sb.o_tx_valid, 1'b0);
      chk("reset_tx_msg", sb.o_TX_SbMessage, 4'd0);
      chk("reset_end", sb.o_end, 1'b0);
      chk("reset_timeout", sb.o_timeout, 1'b0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].start, vecs[i].vld, vecs[i].msg, vecs[i].busy);
         @(posedge clk);
         #1;
         chk($sformatf("%s.tx_valid", vecs[i].tag), sb.o_tx_valid, vecs[i].exp_vld);
         chk($sformatf("%s.tx_msg", vecs[i].tag), sb.o_TX_SbMessage, vecs[i].exp_msg);
         chk($sformatf("%s.end", vecs[i].tag), sb.o_end, vecs[i].exp_end);
         chk($sformatf("%s.timeout", vecs[i].tag), sb.o_timeout, 1'b0);
      end

      // Start held with no RX traffic for a bounded window
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
      first_to = 0;
      tx_after = 0;
      tx_cnt   = 0;
      to_cnt   = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk);
         #1;
         if (sb.o_tx_valid) tx_cnt++;
         if (sb.o_timeout) to_cnt++;
         if (sb.o_timeout && first_to == 0) first_to = cyc;
         else if (first_to != 0 && sb.o_tx_valid) tx_after++;
      end
      chk("idle_window_end", sb.o_end, 1'b0);
`ifdef MBINIT_SB_WATCHDOG_EN
      chk("wd_first_cycle", first_to, 16);
      chk("wd_sticky_cycles", to_cnt, 25);
      chk("wd_tx_after_timeout", tx_after, 0);
      chk("wd_only_req_sent", tx_cnt, 1);
      @(negedge clk);
      sb.i_start = 1'b0;
      @(posedge clk);
      #1;
      chk("wd_clear_on_stop", sb.o_timeout, 1'b0);
`else
      chk("nowd_timeout_count", to_cnt, 0);
      chk("nowd_only_req_sent", tx_cnt, 1);
      @(negedge clk);
      sb.i_start = 1'b0;
      @(posedge clk);
      #1;
      chk("nowd_stop_tx_valid", sb.o_tx_valid, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mbinit_sb_handshake.md
# mbinit_sb_handshake

Parametrised MBINIT sideband handshake engine, the next generation of the per-substate calibration wrapper. It runs one initiator exchange (send REQ, wait RSP) and one responder exchange (wait REQ, send RSP) concurrently. Both exchanges share a single sideband TX port, and the responder has priority. Message codes, message width and an optional watchdog are configurable, so the same block serves CAL, REPAIRCLK, REPAIRVAL and similar MBINIT substates.

## Interface
- MSG_W, 4, sideband message code width
- REQ_CODE, 4'd1, code sent by the initiator and expected by the responder
- RSP_CODE, 4'd2, code sent by the responder and expected by the initiator
- TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with the watchdog macro)

Ports:
- CLK  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  level enable (previous substate done); deassertion aborts the exchange
- i_RX_SbMessage  in  MSG_W  received message code
- i_msg_valid  in  1  single-cycle qualifier for i_RX_SbMessage
- i_falling_edge_busy  in  1  sideband finished sending the last TX message
- o_TX_SbMessage  out  MSG_W  message to send; 0 when o_tx_valid is low
- o_tx_valid  out  1  single-cycle TX request
- o_end  out  1  both exchanges complete
- o_timeout  out  1  watchdog expired (sticky)

## Operation
- Initiator FSM: I_IDLE → I_SEND → I_WAIT_BUSY → I_WAIT_RSP → I_DONE.
  - I_IDLE → I_SEND when i_start=1.
  - I_SEND emits REQ_CODE once it wins arbitration, then goes to I_WAIT_BUSY.
  - I_WAIT_BUSY → I_WAIT_RSP on i_falling_edge_busy while the initiator is the TX owner.
  - I_WAIT_RSP → I_DONE on i_msg_valid && i_RX_SbMessage==RSP_CODE.
- Responder FSM: R_IDLE → R_WAIT_REQ → R_SEND → R_WAIT_BUSY → R_DONE.
  - R_IDLE → R_WAIT_REQ when i_start=1.
  - R_WAIT_REQ → R_SEND on i_msg_valid && i_RX_SbMessage==REQ_CODE.
  - R_SEND always wins arbitration and goes to R_WAIT_BUSY.
  - R_WAIT_BUSY → R_DONE on i_falling_edge_busy while the responder is the TX owner.
- RSP_CODE arriving while the initiator is in I_SEND or I_WAIT_BUSY is latched into a pending flag and consumed on entry to I_WAIT_RSP.
- REQ_CODE arriving before the responder reaches R_WAIT_REQ is latched the same way.
- Arbitration:
  - A registered owner field (NONE/INIT/RESP) records which FSM's message is in flight.
  - A new TX is allowed only when owner=NONE.
  - Responder wins any same-cycle contention.
  - Owner clears to NONE on i_falling_edge_busy.
- i_falling_edge_busy with owner=NONE is ignored.
- Messages other than REQ_CODE/RSP_CODE, or arriving in DONE states, are ignored.
- o_end = I_DONE && R_DONE, registered. It stays high while i_start=1.
- i_start low in any state: both FSMs go to IDLE, owner and pending flags clear, all outputs return to 0 on the next edge.

## Timing
- Reset values: o_TX_SbMessage=0, o_tx_valid=0, o_end=0, o_timeout=0. FSMs in IDLE, owner=NONE, pending flags and watchdog cleared.
- rst asserted mid-exchange takes effect on the next edge, identical to the reset values above.
- All outputs are registered.
- i_start sampled high at edge k → initiator o_tx_valid=1 with REQ_CODE after edge k+1, provided the responder is not sending.
- Valid REQ at edge k → responder o_tx_valid=1 with RSP_CODE after edge k+1 if owner=NONE. Otherwise the responder waits for the owner to clear.
- o_tx_valid is exactly one cycle wide. At most one TX is in flight until i_falling_edge_busy.
- Final event (RSP receive or responder busy-drop) at edge k → o_end=1 after edge k+1.

## Configuration
- MBINIT_SB_WATCHDOG_EN defined:
  - A counter of width $clog2(TIMEOUT_CYC+1) increments each cycle while i_start=1 and o_end=0.
  - When the count reaches TIMEOUT_CYC-1, o_timeout goes high on the next edge.
  - Both FSMs then park in IDLE and ignore all inputs.
  - o_timeout stays high until i_start=0 or rst.
  - The counter saturates and never wraps.
- Not defined: no counter is present, o_timeout is tied 0, and the exchanges wait indefinitely.

## Test plan
- Normal order: i_start=1; busy-drop 3 cycles after REQ; RX REQ 4'd1, then RX RSP 4'd2 → REQ (4'd1) sent, then RSP (4'd2) sent; o_end=1 one cycle after the last event.
- Contention: RX REQ in the same cycle the initiator would send → RSP (4'd2) sent first. REQ (4'd1) is sent one cycle after the busy-drop, never in the same cycle.
- Early RSP: RX 4'd2 before the initiator's busy-drop → pending flag latched; o_end still asserts once the responder completes.
- Noise: RX 4'd7 and a busy-drop with owner=NONE → no state change, o_tx_valid stays 0.
- Abort: i_start dropped while waiting for RSP, then reasserted → all outputs 0 next cycle, then a clean restart with REQ resent.
- Watchdog (macro on, TIMEOUT_CYC=16): no RX traffic → o_timeout=1 after 16 cycles, o_end=0, no further TX until i_start=0.
